idu_pipe: RTL and testbench

//  Registered RV32I/RV64I+Zicsr decode stage between ifu and exu. Decodes each fetched word into a

---
 rtl/idu_pipe.sv | 230 +++++++++++++++++++++++
 tb/tb_idu_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_pipe.sv
// Registered RV32I/RV64I+Zicsr decode stage: comb decode into a 2-entry skid FIFO,
// with RAW hazard stalling against in-flight writers, flush and illegal detection.
module idu_pipe #(
    parameter int unsigned DATA_LEN = 32,
    parameter int unsigned HZ_PORTS = 2,
    parameter logic [63:0] RST_PC   = 64'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_inst,
    input  logic [DATA_LEN-1:0]   in_pc,
    input  logic [HZ_PORTS-1:0]   hz_valid,
    input  logic [5*HZ_PORTS-1:0] hz_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_LEN-1:0]   out_pc,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [4:0]            out_rd,
    output logic [DATA_LEN-1:0]   out_imm,
    output logic [11:0]           out_csr_addr,
    output logic [2:0]            out_funct3,
    output logic                  out_alt,
    output logic [7:0]            out_cls,
    output logic [2:0]            out_sys,
    output logic                  out_rd_wen
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [31:0] INST_NOP    = 32'h0000_0013;
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;
    localparam bit IS32 = (DATA_LEN == 32);

    typedef struct packed {
        logic [DATA_LEN-1:0] pc;
        logic [DATA_LEN-1:0] imm;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [11:0]         csr_addr;
        logic [2:0]          funct3;
        logic                alt;
        logic [7:0]          cls;
        logic [2:0]          sys;
        logic                rd_wen;
    } entry_t;

    // Full decode of one instruction word into the FIFO payload.
    function automatic entry_t decode(input logic [31:0] inst, input logic [DATA_LEN-1:0] pc);
        entry_t     e;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op, is_sys;
        logic is_csr, is_csr_i, is_ecall, is_ebreak, is_mret, known, ill;

        opc       = inst[6:0];
        f3        = inst[14:12];
        f7        = inst[31:25];
        is_lui    = (opc == OP_LUI);
        is_auipc  = (opc == OP_AUIPC);
        is_jal    = (opc == OP_JAL);
        is_jalr   = (opc == OP_JALR);
        is_br     = (opc == OP_BRANCH);
        is_ld     = (opc == OP_LOAD);
        is_st     = (opc == OP_STORE);
        is_opi    = (opc == OP_IMM);
        is_op     = (opc == OP_OP);
        is_sys    = (opc == OP_SYSTEM);
        is_csr    = is_sys && (f3 != 3'd0);
        is_csr_i  = is_sys && f3[2];
        is_ecall  = (inst == INST_ECALL);
        is_ebreak = (inst == INST_EBREAK);
        is_mret   = (inst == INST_MRET);
        known     = is_lui | is_auipc | is_jal | is_jalr | is_br | is_ld | is_st
                  | is_opi | is_op | is_sys;

        ill = (inst[1:0] != 2'b11) || !known;
        ill = ill || (is_br && (f3 == 3'd2 || f3 == 3'd3));
        ill = ill || (is_ld && (f3 == 3'd7 || (IS32 && (f3 == 3'd3 || f3 == 3'd6))));
        ill = ill || (is_op && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))));
        // slli allows no high bits; srli/srai allow only inst[30]
        ill = ill || (is_opi && f3 == 3'd1 && (inst[31:26] != 6'd0 || (IS32 && inst[25])));
        ill = ill || (is_opi && f3 == 3'd5
                      && ({inst[31], inst[29:26]} != 5'd0 || (IS32 && inst[25])));
        ill = ill || (is_sys && f3 == 3'd4);
        ill = ill || (is_sys && f3 == 3'd0 && !(is_ecall || is_ebreak || is_mret));

        e.pc       = pc;
        e.rs1      = inst[19:15];
        e.rs2      = inst[24:20];
        e.rd       = inst[11:7];
        e.csr_addr = inst[31:20];
        e.funct3   = f3;
        e.alt      = inst[30];

        if (is_csr_i)
            e.imm = DATA_LEN'(inst[19:15]);
        else if (is_st)
            e.imm = DATA_LEN'($signed({inst[31:25], inst[11:7]}));
        else if (is_br)
            e.imm = DATA_LEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        else if (is_lui || is_auipc)
            e.imm = DATA_LEN'($signed({inst[31:12], 12'b0}));
        else if (is_jal)
            e.imm = DATA_LEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        else if (is_ld || is_opi || is_jalr || is_sys)
            e.imm = DATA_LEN'($signed(inst[31:20]));
        else
            e.imm = '0;

        if (ill) begin
            e.cls    = 8'h80;
            e.sys    = 3'b000;
            e.rd_wen = 1'b0;
        end else begin
            e.cls    = {1'b0, is_sys && f3 == 3'd0, is_csr, is_jalr, is_jal, is_br, is_st, is_ld};
            e.sys    = {is_ebreak, is_mret, is_ecall};
            e.rd_wen = (inst[11:7] != 5'd0)
                     && (is_op || is_opi || is_ld || is_lui || is_auipc
                         || is_jal || is_jalr || is_csr);
        end
        return e;
    endfunction

    localparam entry_t RST_ENTRY = decode(INST_NOP, DATA_LEN'(RST_PC));

    entry_t     ent0;
    entry_t     ent1;
    entry_t     dec;
    entry_t     head_e;
    logic       head;
    logic       tail;
    logic [1:0] count;
    logic [1:0] count_next;
    logic       hz_stall;
    logic       rs1_used;
    logic       rs2_used;
    logic       push;
    logic       pop;

    assign dec = decode(in_inst, in_pc);

    // RAW hazard check of the incoming word's source registers.
    always_comb begin
        hz_stall = 1'b0;
        rs1_used = !(in_inst[6:0] == OP_LUI || in_inst[6:0] == OP_AUIPC
                     || in_inst[6:0] == OP_JAL
                     || (in_inst[6:0] == OP_SYSTEM && in_inst[14]));
        rs2_used = (in_inst[6:0] == OP_BRANCH) || (in_inst[6:0] == OP_STORE)
                || (in_inst[6:0] == OP_OP);
        for (int unsigned i = 0; i < HZ_PORTS; i++) begin
            if (hz_valid[i] && hz_rd[5*i +: 5] != 5'd0
                && ((rs1_used && hz_rd[5*i +: 5] == in_inst[19:15])
                    || (rs2_used && hz_rd[5*i +: 5] == in_inst[24:20])))
                hz_stall = 1'b1;
        end
    end

    assign in_ready = !count[1] && !hz_stall && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready && !flush;

    always_comb begin
        count_next = count;
        if (flush)
            count_next = 2'd0;
        else if (push && !pop)
            count_next = count + 2'd1;
        else if (pop && !push)
            count_next = count - 2'd1;
    end

    // FIFO storage, pointers and registered valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0      <= RST_ENTRY;
            ent1      <= RST_ENTRY;
            head      <= 1'b0;
            tail      <= 1'b0;
            count     <= 2'd0;
            out_valid <= 1'b0;
        end else begin
            count     <= count_next;
            out_valid <= (count_next != 2'd0);
            if (flush) begin
                head <= 1'b0;
                tail <= 1'b0;
            end else begin
                if (push) begin
                    if (tail)
                        ent1 <= dec;
                    else
                        ent0 <= dec;
                    tail <= !tail;
                end
                if (pop)
                    head <= !head;
            end
        end
    end

    assign head_e       = head ? ent1 : ent0;
    assign out_pc       = head_e.pc;
    assign out_rs1      = head_e.rs1;
    assign out_rs2      = head_e.rs2;
    assign out_rd       = head_e.rd;
    assign out_imm      = head_e.imm;
    assign out_csr_addr = head_e.csr_addr;
    assign out_funct3   = head_e.funct3;
    assign out_alt      = head_e.alt;
    assign out_cls      = head_e.cls;
    assign out_sys      = head_e.sys;
    assign out_rd_wen   = head_e.rd_wen;

endmodule

// File: tb/tb_idu_pipe.sv
// Directed bench for idu_pipe: a 64-bit instance carries the main stream, a 32-bit
// instance sees the same stimulus for the DATA_LEN-dependent legality rules.
module tb_idu_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic [1:0]  hz_valid;
    logic [9:0]  hz_rd;
    logic        out_ready;

    logic        in_ready, out_valid, out_alt, out_rd_wen;
    logic [63:0] out_pc, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [11:0] out_csr_addr;
    logic [2:0]  out_funct3, out_sys;
    logic [7:0]  out_cls;

    logic        s_in_ready, s_out_valid, s_out_alt, s_out_rd_wen;
    logic [31:0] s_out_pc, s_out_imm;
    logic [4:0]  s_out_rs1, s_out_rs2, s_out_rd;
    logic [11:0] s_out_csr_addr;
    logic [2:0]  s_out_funct3, s_out_sys;
    logic [7:0]  s_out_cls;

    int checks;
    int failures;

    idu_pipe #(.DATA_LEN(64), .HZ_PORTS(2), .RST_PC(64'h8000_0000)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .hz_valid(hz_valid), .hz_rd(hz_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm), .out_csr_addr(out_csr_addr),
        .out_funct3(out_funct3), .out_alt(out_alt), .out_cls(out_cls), .out_sys(out_sys),
        .out_rd_wen(out_rd_wen)
    );

    idu_pipe #(.DATA_LEN(32), .HZ_PORTS(2), .RST_PC(64'h8000_0000)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_inst(in_inst), .in_pc(in_pc[31:0]), .hz_valid(hz_valid), .hz_rd(hz_rd),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc), .out_rs1(s_out_rs1),
        .out_rs2(s_out_rs2), .out_rd(s_out_rd), .out_imm(s_out_imm),
        .out_csr_addr(s_out_csr_addr), .out_funct3(s_out_funct3), .out_alt(s_out_alt),
        .out_cls(s_out_cls), .out_sys(s_out_sys), .out_rd_wen(s_out_rd_wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted word, presented for exactly one edge.
    task automatic push(input logic [31:0] inst, input logic [63:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = 32'h0;
        in_pc     = 64'h0;
        hz_valid  = 2'b00;
        hz_rd     = 10'd0;
        out_ready = 1'b0;

        #12;
        chk("rst_valid",  64'(out_valid), 64'd0);
        chk("rst_pc",     out_pc, 64'h8000_0000);
        chk("rst_imm",    out_imm, 64'd0);
        chk("rst_cls",    64'(out_cls), 64'd0);
        chk("rst_wen",    64'(out_rd_wen), 64'd0);
        chk("rst_sys",    64'(out_sys), 64'd0);
        chk("rst_pc32",   64'(s_out_pc), 64'h8000_0000);
        rst = 1'b0;
        tick();

        // addi x1,x0,-1 then jal x0,0
        #1 chk("empty_ready", 64'(in_ready), 64'd1);
        push(32'hFFF0_0093, 64'h100);
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_pc",    out_pc, 64'h100);
        chk("addi_imm",   out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_wen",   64'(out_rd_wen), 64'd1);
        chk("addi_rd",    64'(out_rd), 64'd1);
        chk("addi_cls",   64'(out_cls), 64'd0);
        chk("addi_imm32", 64'(s_out_imm), 64'hFFFF_FFFF);
        pop();
        chk("addi_drained", 64'(out_valid), 64'd0);
        push(32'h0000_006F, 64'h104);
        chk("jal_cls", 64'(out_cls), 64'h08);
        chk("jal_wen", 64'(out_rd_wen), 64'd0);
        chk("jal_imm", out_imm, 64'd0);
        pop();

        // Backpressure: two accepted, third refused, drained in order
        push(32'h0050_0113, 64'h200);
        push(32'h0060_0193, 64'h204);
        in_valid = 1'b1;
        in_inst  = 32'h0070_0213;
        in_pc    = 64'h208;
        #1 chk("full_ready", 64'(in_ready), 64'd0);
        tick();
        chk("full_hold_pc", out_pc, 64'h200);
        chk("full_hold_imm", out_imm, 64'd5);
        out_ready = 1'b1;
        #1 chk("full_pop_ready", 64'(in_ready), 64'd0);
        tick();
        chk("drain1_pc", out_pc, 64'h204);
        chk("drain1_rd", 64'(out_rd), 64'd3);
        chk("reopen_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("drain2_pc", out_pc, 64'h208);
        chk("drain2_valid", 64'(out_valid), 64'd1);
        tick();
        out_ready = 1'b0;
        chk("drain_empty", 64'(out_valid), 64'd0);

        // Hazard on rs1 via port 0, rs2 via port 1
        hz_valid = 2'b01;
        hz_rd    = {5'd0, 5'd3};
        in_valid = 1'b1;
        in_inst  = 32'h0051_8233;
        in_pc    = 64'h300;
        #1 chk("hz_rs1_ready", 64'(in_ready), 64'd0);
        tick();
        chk("hz_no_push", 64'(out_valid), 64'd0);
        hz_valid = 2'b10;
        hz_rd    = {5'd5, 5'd0};
        #1 chk("hz_rs2_ready", 64'(in_ready), 64'd0);
        hz_valid = 2'b01;
        hz_rd    = {5'd0, 5'd3};
        in_inst  = 32'h0001_81B7;
        in_pc    = 64'h304;
        #1 chk("hz_lui_ready", 64'(in_ready), 64'd1);
        tick();
        chk("lui_imm", out_imm, 64'h1_8000);
        chk("lui_wen", 64'(out_rd_wen), 64'd1);
        hz_valid  = 2'b00;
        in_inst   = 32'h0051_8233;
        in_pc     = 64'h308;
        out_ready = 1'b1;
        #1 chk("hz_clear_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("add_pc",  out_pc, 64'h308);
        chk("add_rs1", 64'(out_rs1), 64'd3);
        chk("add_rs2", 64'(out_rs2), 64'd5);
        chk("add_wen", 64'(out_rd_wen), 64'd1);
        pop();

        // Flush with full FIFO and a word on the input
        push(32'h0050_0113, 64'h400);
        push(32'h0060_0193, 64'h404);
        in_valid  = 1'b1;
        in_inst   = 32'h0070_0213;
        in_pc     = 64'h408;
        out_ready = 1'b1;
        flush     = 1'b1;
        #1 chk("flush_ready", 64'(in_ready), 64'd0);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        tick();
        chk("flush_stays_empty", 64'(out_valid), 64'd0);
        push(32'h0000_0013, 64'h500);
        chk("post_flush_pc", out_pc, 64'h500);
        pop();

        // Illegal encodings and system/CSR decodes
        push(32'h0200_0033, 64'h600);
        chk("mul_cls", 64'(out_cls), 64'h80);
        chk("mul_wen", 64'(out_rd_wen), 64'd0);
        pop();
        push(32'h0000_0000, 64'h604);
        chk("zero_cls", 64'(out_cls), 64'h80);
        pop();
        push(32'h0200_9093, 64'h608);
        chk("slli32_cls64", 64'(out_cls), 64'h00);
        chk("slli32_wen64", 64'(out_rd_wen), 64'd1);
        chk("slli32_cls32", 64'(s_out_cls), 64'h80);
        chk("slli32_wen32", 64'(s_out_rd_wen), 64'd0);
        pop();
        push(32'h0010_0073, 64'h60C);
        chk("ebreak_sys", 64'(out_sys), 64'b100);
        chk("ebreak_cls", 64'(out_cls), 64'h40);
        pop();
        push(32'h3020_0073, 64'h610);
        chk("mret_sys", 64'(out_sys), 64'b010);
        pop();
        push(32'h0000_2063, 64'h614);
        chk("br_f3_2_cls", 64'(out_cls), 64'h80);
        pop();
        push(32'h0000_3083, 64'h618);
        chk("ld_cls64", 64'(out_cls), 64'h01);
        chk("ld_cls32", 64'(s_out_cls), 64'h80);
        pop();
        push(32'h3002_D0F3, 64'h61C);
        chk("csrrwi_cls", 64'(out_cls), 64'h20);
        chk("csrrwi_imm", out_imm, 64'd5);
        chk("csrrwi_addr", 64'(out_csr_addr), 64'h300);
        chk("csrrwi_wen", 64'(out_rd_wen), 64'd1);
        pop();

        // Asynchronous reset with two entries held
        push(32'h0050_0113, 64'h700);
        push(32'h0060_0193, 64'h704);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_pc",    out_pc, 64'h8000_0000);
        chk("mid_rst_cls",   64'(out_cls), 64'd0);
        chk("mid_rst_rd",    64'(out_rd), 64'd0);
        #3 rst = 1'b0;
        tick();
        chk("post_rst_valid", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
